// File: rtl/day26_comparator_new_approach.sv
// day26_comparator_new_approach
//   Unsigned K-bit magnitude comparator built as a group-compare tree.
//   Level 0 compares 2-bit slices. Each merge level then combines adjacent
//   slice results, and the more significant slice wins.
//   The root (gt, lt) pair is decoded into three registered one-hot flags.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears every flop
//   a, b         K-bit unsigned operands
//   a_equal_b    registered, a == b
//   a_greater_b  registered, a >  b
//   b_greater_a  registered, b >  a
//
// Build option
//   DAY26_COMPARATOR_INPUT_REG_EN : registers a/b before the tree (2-cycle
//   latency). When it is undefined, the tree reads the ports directly
//   (1-cycle latency).
module day26_comparator_new_approach #(
  parameter int K = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic         a_equal_b,
  output logic         a_greater_b,
  output logic         b_greater_a
);

  localparam int NG     = (K + 1) / 2;              // number of 2-bit groups
  localparam int KP     = 2 * NG;                   // padded width
  localparam int LEVELS = (NG > 1) ? $clog2(NG) : 0;

  // Node count at tree level l: ceil(NG / 2^l)
  function automatic int cnt(input int l);
    return (NG + (1 << l) - 1) >> l;
  endfunction

  // ---------------------------------------------------------------------
  // Operand source
  // ---------------------------------------------------------------------
  logic [K-1:0] a_src, b_src;

`ifdef DAY26_COMPARATOR_INPUT_REG_EN
  logic [K-1:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign a_src = a_q;
  assign b_src = b_q;
`else
  assign a_src = a;
  assign b_src = b;
`endif

  // Zero-extend to an even width so that every group holds exactly 2 bits.
  logic [KP-1:0] a_pad, b_pad;
  assign a_pad = KP'(a_src);
  assign b_pad = KP'(b_src);

  // ---------------------------------------------------------------------
  // Compare tree. Each level lives in its own generate scope and is sized
  // exactly. The next level reads the previous one through g_lvl[l-1].
  // ---------------------------------------------------------------------
  genvar l, j;
  generate
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
      logic [cnt(l)-1:0] gt, lt;

      if (l == 0) begin : g_leaf
        for (j = 0; j < NG; j++) begin : g_grp
          assign gt[j] = a_pad[2*j +: 2] > b_pad[2*j +: 2];
          assign lt[j] = a_pad[2*j +: 2] < b_pad[2*j +: 2];
        end
      end else begin : g_merge
        for (j = 0; j < cnt(l); j++) begin : g_node
          if (2*j + 1 < cnt(l-1)) begin : g_pair
            // The high slice decides unless it is equal. In that case the
            // low slice decides.
            assign gt[j] = g_lvl[l-1].gt[2*j+1] |
                           (~g_lvl[l-1].lt[2*j+1] & g_lvl[l-1].gt[2*j]);
            assign lt[j] = g_lvl[l-1].lt[2*j+1] |
                           (~g_lvl[l-1].gt[2*j+1] & g_lvl[l-1].lt[2*j]);
          end else begin : g_pass
            // An odd node at the top of this level passes through unchanged.
            assign gt[j] = g_lvl[l-1].gt[2*j];
            assign lt[j] = g_lvl[l-1].lt[2*j];
          end
        end
      end
    end
  endgenerate

  logic gt_root, lt_root;
  assign gt_root = g_lvl[LEVELS].gt[0];
  assign lt_root = g_lvl[LEVELS].lt[0];

  // ---------------------------------------------------------------------
  // Output flags, loaded every cycle
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_equal_b   <= 1'b0;
      a_greater_b <= 1'b0;
      b_greater_a <= 1'b0;
    end else begin
      a_equal_b   <= ~gt_root & ~lt_root;
      a_greater_b <= gt_root;
      b_greater_a <= lt_root;
    end
  end

endmodule

// File: tb/tb_day26_comparator_new_approach.sv
module tb_day26_comparator_new_approach;

`ifdef DAY26_COMPARATOR_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] a = '0, b = '0;
  logic [6:0]  a7 = '0, b7 = '0;
  logic        eq20, gt20, lt20, eq7, gt7, lt7;

  always #5 clk = ~clk;

  day26_comparator_new_approach #(.K(20)) dut20 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .a_equal_b(eq20), .a_greater_b(gt20), .b_greater_a(lt20));

  day26_comparator_new_approach #(.K(7)) dut7 (
    .clk(clk), .reset(reset), .a(a7), .b(b7),
    .a_equal_b(eq7), .a_greater_b(gt7), .b_greater_a(lt7));

  int tests = 0;
  int failed = 0;

  // Flags are packed as {a_greater_b, a_equal_b, b_greater_a}.
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // Reference model. An edge that sees reset produces all-zero flags.
  // Otherwise the flags compare the operand pair sampled LAT-1 edges earlier.
  // A pair sampled during reset counts as (0, 0).
  logic [19:0] pa_q = '0, pb_q = '0;
  logic [6:0]  pa7_q = '0, pb7_q = '0;
  logic [2:0]  exp20 = '0, exp7 = '0;

  always @(posedge clk) begin
    logic [19:0] sa, sb;
    logic [6:0]  sa7, sb7;
    if (LAT == 1) begin
      sa = a; sb = b; sa7 = a7; sb7 = b7;
    end else begin
      sa = pa_q; sb = pb_q; sa7 = pa7_q; sb7 = pb7_q;
    end
    exp20 <= reset ? 3'b000 : ref_cmp(32'(sa), 32'(sb));
    exp7  <= reset ? 3'b000 : ref_cmp(32'(sa7), 32'(sb7));
    pa_q  <= reset ? '0 : a;
    pb_q  <= reset ? '0 : b;
    pa7_q <= reset ? '0 : a7;
    pb7_q <= reset ? '0 : b7;
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_onehot(input string tag, input logic [2:0] obs);
    tests++;
    assert ($onehot(obs)) else begin
      failed++;
      $error("FAIL %s observed=%b expected=one-hot", tag, obs);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a pair for LAT cycles, then check the 20-bit flags against a constant.
  task automatic dir(input string tag, input logic [19:0] av, input logic [19:0] bv,
                     input logic [2:0] exp);
    a = av; b = bv;
    cyc(LAT);
    chk(tag, {gt20, eq20, lt20}, exp);
  endtask

  initial begin
    // Reset with a > b on the bus.
    reset = 1'b1; a = 20'hFFFFF; b = 20'h0;
    cyc(2);
    chk("reset20", {gt20, eq20, lt20}, 3'b000);
    chk("reset7",  {gt7, eq7, lt7},    3'b000);
    reset = 1'b0;
    cyc(LAT);
    chk("reset_exit", {gt20, eq20, lt20}, 3'b100);

    dir("eq_5a5a5",  20'h5A5A5, 20'h5A5A5, 3'b010);
    dir("eq_zero",   20'h00000, 20'h00000, 3'b010);
    dir("eq_full",   20'hFFFFF, 20'hFFFFF, 3'b010);
    dir("msb_a",     20'h80000, 20'h7FFFF, 3'b100);
    dir("msb_b",     20'h7FFFF, 20'h80000, 3'b001);
    dir("lsb_b",     20'h12344, 20'h12345, 3'b001);
    dir("lsb_a",     20'h12345, 20'h12344, 3'b100);
    dir("full_vs_0", 20'hFFFFF, 20'h00000, 3'b100);

    // Back-to-back random pairs. Some cases are biased toward equal operands,
    // toward pairs that differ only in bit 0, and toward pairs that differ
    // only in the MSB.
    for (int i = 0; i < 1000; i++) begin
      int sel;
      @(negedge clk);
      chk("b2b20", {gt20, eq20, lt20}, exp20);
      chk_onehot("onehot20", {gt20, eq20, lt20});
      chk("b2b7", {gt7, eq7, lt7}, exp7);
      sel = $urandom_range(0, 7);
      a  = 20'($urandom);
      a7 = 7'($urandom);
      b7 = 7'($urandom);
      case (sel)
        0:       b = a;
        1:       b = a ^ 20'h00001;
        2:       b = a ^ 20'h80000;
        default: b = 20'($urandom);
      endcase
    end

    // Reset in the middle of traffic drops whatever was in flight.
    a = 20'h00003; b = 20'h00001;
    reset = 1'b1;
    cyc(1);
    chk("midreset20", {gt20, eq20, lt20}, 3'b000);
    chk("midreset7",  {gt7, eq7, lt7},    3'b000);
    reset = 1'b0;

    // Exhaustive sweep of the odd-width instance.
    for (int x = 0; x < 128; x++) begin
      for (int y = 0; y < 128; y++) begin
        a7 = 7'(x); b7 = 7'(y);
        cyc(1);
        chk("sweep7", {gt7, eq7, lt7}, exp7);
      end
    end
    cyc(LAT);
    chk("sweep7_last", {gt7, eq7, lt7}, ref_cmp(32'd127, 32'd127));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
